icu_biu_refill: RTL and testbench
=================================

// Module: icu_biu_refill
// PURPOSE
//  Bus-interface refill engine directly downstream of the icache (icu). Accepts one
//  line-fill request on icu_biu_req/addr and acks it for one cycle. Fetches the 32-byte
//  line as 4 x 64-bit reads on a single-outstanding memory port, critical word first.
//  Returns each beat to the icu on biu_icu_data_valid/data, flagging the 4th with data_last.
// PARAMETERS
//  DATA_W   64  beat width; fixed, only 64 is supported
//  BEATS    4   beats per line; fixed, 32-byte line
//  CWF      1   1: start at addr[4:3] and wrap mod 4; 0: always start at beat 0
// PORTS
//  clk                 in   1   single clock, all logic on posedge
//  resetn              in   1   asynchronous, active-low reset
//  icu_biu_req         in   1   level refill request; icu holds until it sees ack
//  icu_biu_addr        in   29  [31:3] miss address; [31:5]=line, [4:3]=critical beat
//  biu_icu_ack         out  1   one-cycle accept pulse
//  biu_icu_data_valid  out  1   one-cycle pulse per returned beat
//  biu_icu_data        out  64  beat data, valid only with data_valid
//  biu_icu_data_last   out  1   high with data_valid on the 4th beat only
//  biu_icu_data_err    out  1   high with data_valid if that beat's read errored
//  mem_req             out  1   read request, held until mem_gnt
//  mem_addr            out  32  {line[31:5], beat[1:0], 3'b000}
//  mem_gnt             in   1   request accepted this cycle
//  mem_rvalid          in   1   read data valid; earliest 1 cycle after gnt
//  mem_rdata           in   64  read data
//  mem_rerr            in   1   read error, sampled with mem_rvalid
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, beat counter 0, latched addr 0.
//   Reset mid-burst aborts immediately; no further icu beats.
//   A mem_rvalid for the aborted read is ignored once back in IDLE.
//  FSM: IDLE -> ACK -> REQ -> WAIT -> (REQ | IDLE)
//   IDLE: if icu_biu_req, latch addr, set beat=CWF?addr[4:3]:0, cnt=0, go ACK.
//   ACK : biu_icu_ack=1 this cycle only; go REQ. Latency req->ack = 1 cycle.
//   REQ : mem_req=1, mem_addr per beat; on mem_gnt go WAIT.
//         mem_req/mem_addr are registered; mem_req drops the cycle after gnt.
//   WAIT: on mem_rvalid, register rdata/rerr to biu_icu_data/err and pulse data_valid
//         the next cycle, with data_last=(cnt==3). Then beat=beat+1 (2-bit wrap),
//         cnt=cnt+1. If cnt was 3, go IDLE; else go REQ.
//  Requests: accepted only in IDLE; while busy req is ignored, with no ack and no queue.
//   New req in the cycle the last data_valid is driven is accepted; ack comes 1 cycle later.
//   Minimum gap between a fill's last beat and the next fill's ack: 1 cycle.
//  Errors: mem_rerr does not shorten the burst; all 4 beats are always returned.
//   data_err is per-beat.
//  Output data holds its last value when data_valid=0; no clearing required.
//  Exactly one ack and exactly 4 data_valid pulses per accepted request; never overlapped.
// TESTING
//  1 Reset then req=1 addr=29'h2021 (miss at 0x00010108), mem gnt same cycle,
//    rvalid +1 cycle -> ack 1 cycle after req; mem_addr 0x00010108, 0x10, 0x18, 0x00;
//    4 valids, last only on 4th.
//  2 CWF=0, addr=29'h2022 -> mem_addr order 0x00010100,0x08,0x10,0x18; data returned
//    in that order (e.g. bbbb.., cccc.., dddd.., eeee..).
//  3 mem_gnt delayed 3 cycles per beat, rvalid delayed 5 -> mem_req held steady,
//    mem_addr stable while waiting, no extra valids.
//  4 Req held high through a whole fill, then dropped 1 cycle after ack -> exactly
//    one ack; second req 1 cycle after last beat -> second ack/fill proceeds normally.
//  5 mem_rerr=1 on beat 2 only -> data_err high only with the 2nd data_valid;
//    burst completes with last.
//  6 Drive resetn=0 after 2 beats, release, then rvalid arrives -> outputs 0,
//    no valid pulse; a fresh req afterwards gets a normal 4-beat fill.

Source files
------------

// File: rtl/icu_biu_refill.sv
// -----------------------------------------------------------------------------
// icu_biu_refill
//
// Purpose:
//   Refill engine between the instruction cache and the memory bus. It accepts
//   one line-fill request, acknowledges it with a single-cycle pulse, and then
//   fetches the 32-byte line as four 64-bit reads on a single-outstanding memory
//   port. The fetch normally starts at the critical (missing) beat and wraps
//   modulo 4. Each returned beat is forwarded to the cache with a one-cycle valid
//   pulse. The fourth beat is flagged with data_last.
//
// Parameters:
//   DATA_W  beat width (only 64 is supported)
//   BEATS   beats per line (only 4 is supported)
//   CWF     1: critical word first, start at addr[4:3] and wrap
//           0: always start at beat 0
//
// Ports:
//   clk, resetn          clock (posedge) and asynchronous active-low reset
//   icu_biu_req/addr     level fill request and miss address [31:3] from icache
//   biu_icu_ack          one-cycle accept pulse
//   biu_icu_data_*       returned beat: valid pulse, data, last flag, error flag
//   mem_req/addr         registered read request, held until mem_gnt
//   mem_gnt              request accepted
//   mem_rvalid/rdata     read data return, with per-read error mem_rerr
// -----------------------------------------------------------------------------
module icu_biu_refill #(
  parameter int DATA_W = 64,
  parameter int BEATS  = 4,
  parameter int CWF    = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              icu_biu_req,
  input  logic [31:3]       icu_biu_addr,
  output logic              biu_icu_ack,
  output logic              biu_icu_data_valid,
  output logic [DATA_W-1:0] biu_icu_data,
  output logic              biu_icu_data_last,
  output logic              biu_icu_data_err,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rerr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    REQ  = 2'd2,
    WAIT = 2'd3
  } state_e;

  localparam logic [1:0] LAST_CNT = 2'(BEATS - 1);

  state_e              state_q, state_d;
  logic [31:5]         line_q, line_d;
  logic [1:0]          beat_q, beat_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                ack_q, ack_d;
  logic                mem_req_q, mem_req_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic [1:0]          next_beat;

  // Beat index of the read that follows the current one (2-bit wrap).
  assign next_beat = beat_q + 2'd1;

  // Next-state and registered-output logic. Pulse outputs (ack, valid, last)
  // default low every cycle. The data and error outputs hold their value
  // between beats.
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    beat_d     = beat_q;
    cnt_d      = cnt_q;
    ack_d      = 1'b0;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    valid_d    = 1'b0;
    data_d     = data_q;
    last_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (icu_biu_req) begin
          line_d  = icu_biu_addr[31:5];
          beat_d  = (CWF != 0) ? icu_biu_addr[4:3] : 2'd0;
          cnt_d   = 2'd0;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end

      ACK: begin
        mem_req_d  = 1'b1;
        mem_addr_d = {line_q, beat_q, 3'b000};
        state_d    = REQ;
      end

      REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = WAIT;
        end
      end

      WAIT: begin
        if (mem_rvalid) begin
          data_d  = mem_rdata;
          err_d   = mem_rerr;
          valid_d = 1'b1;
          last_d  = (cnt_q == LAST_CNT);
          beat_d  = next_beat;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == LAST_CNT) begin
            state_d = IDLE;
          end else begin
            // The next read is issued in the same cycle the beat goes back to
            // the cache. This keeps one read outstanding with no bubble.
            mem_req_d  = 1'b1;
            mem_addr_d = {line_q, next_beat, 3'b000};
            state_d    = REQ;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register. Reset aborts any burst in progress at once. A late read
  // return then lands in IDLE, where it is ignored.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      line_q     <= '0;
      beat_q     <= 2'd0;
      cnt_q      <= 2'd0;
      ack_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

  assign biu_icu_ack        = ack_q;
  assign biu_icu_data_valid = valid_q;
  assign biu_icu_data       = data_q;
  assign biu_icu_data_last  = last_q;
  assign biu_icu_data_err   = err_q;
  assign mem_req            = mem_req_q;
  assign mem_addr           = mem_addr_q;

endmodule

// File: tb/tb_icu_biu_refill.sv
// -----------------------------------------------------------------------------
// tb_icu_biu_refill
//
// Drives two refill engines: instance 0 is critical-word-first, instance 1
// always starts at beat 0. A memory responder answers each instance's reads
// with programmable grant and read-return delays. Read data is a fixed function
// of the address and a per-fill salt. The error flag comes from a per-beat mask.
// The expected beat order, addresses, data and flags are derived from the miss
// address with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_icu_biu_refill;

  logic        clk = 1'b0;
  logic        resetn;

  logic        icu_req   [2];
  logic [28:0] icu_addr  [2];
  logic        ack       [2];
  logic        dv        [2];
  logic [63:0] ddata     [2];
  logic        dlast     [2];
  logic        derr      [2];
  logic        mreq      [2];
  logic [31:0] maddr     [2];
  logic        mgnt      [2];
  logic        mrv       [2];
  logic [63:0] mrdata    [2];
  logic        mrerr     [2];

  // Memory responder knobs, per instance.
  int          gd_lo [2];
  int          gd_hi [2];
  int          rd_lo [2];
  int          rd_hi [2];
  logic [31:0] salt    [2];
  logic [3:0]  errmask [2];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    icu_biu_refill #(
      .DATA_W (64),
      .BEATS  (4),
      .CWF    ((g == 0) ? 1 : 0)
    ) dut (
      .clk                (clk),
      .resetn             (resetn),
      .icu_biu_req        (icu_req[g]),
      .icu_biu_addr       (icu_addr[g]),
      .biu_icu_ack        (ack[g]),
      .biu_icu_data_valid (dv[g]),
      .biu_icu_data       (ddata[g]),
      .biu_icu_data_last  (dlast[g]),
      .biu_icu_data_err   (derr[g]),
      .mem_req            (mreq[g]),
      .mem_addr           (maddr[g]),
      .mem_gnt            (mgnt[g]),
      .mem_rvalid         (mrv[g]),
      .mem_rdata          (mrdata[g]),
      .mem_rerr           (mrerr[g])
    );
  end

  // Memory contents: a fixed function of the address and the current salt.
  function automatic logic [63:0] mem_word(input logic [31:0] a, input logic [31:0] s);
    return {a ^ s, (~a) + s};
  endfunction

  // Memory responder. It sees mem_req at a negedge, waits the grant delay,
  // grants, then returns data after the read delay. The earliest return is
  // the cycle after the grant.
  initial begin : mem_responder
    int          gwait [2];
    int          rwait [2];
    bit          pend  [2];
    logic [31:0] paddr [2];
    for (int g = 0; g < 2; g++) begin
      mgnt[g] = 1'b0; mrv[g] = 1'b0; mrerr[g] = 1'b0; mrdata[g] = '0;
      gwait[g] = -1; rwait[g] = 0; pend[g] = 1'b0; paddr[g] = '0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        mgnt[g]  = 1'b0;
        mrv[g]   = 1'b0;
        mrerr[g] = 1'b0;
        if (pend[g]) begin
          if (rwait[g] == 0) begin
            mrv[g]    = 1'b1;
            mrdata[g] = mem_word(paddr[g], salt[g]);
            mrerr[g]  = errmask[g][paddr[g][4:3]];
            pend[g]   = 1'b0;
          end else begin
            rwait[g]--;
          end
        end else if (mreq[g] === 1'b1) begin
          if (gwait[g] < 0) gwait[g] = int'($urandom_range(gd_hi[g], gd_lo[g]));
          if (gwait[g] == 0) begin
            mgnt[g]  = 1'b1;
            pend[g]  = 1'b1;
            paddr[g] = maddr[g];
            rwait[g] = int'($urandom_range(rd_hi[g], rd_lo[g]));
            gwait[g] = -1;
          end else begin
            gwait[g]--;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input int g, input int glo, input int ghi, input int rlo,
                         input int rhi, input logic [31:0] s, input logic [3:0] em);
    gd_lo[g] = glo; gd_hi[g] = ghi; rd_lo[g] = rlo; rd_hi[g] = rhi;
    salt[g] = s; errmask[g] = em;
  endtask

  // Check that an instance is quiet for n cycles: no ack, no beats, no reads.
  task automatic idle_check(input int g, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_ack", g), ack[g], 1'b0);
      chk($sformatf("idle%0d_valid", g), dv[g], 1'b0);
      chk($sformatf("idle%0d_mem_req", g), mreq[g], 1'b0);
    end
  endtask

  task automatic reset_outputs_check(input int g);
    chk($sformatf("rst%0d_ack", g), ack[g], 1'b0);
    chk($sformatf("rst%0d_valid", g), dv[g], 1'b0);
    chk($sformatf("rst%0d_data", g), ddata[g], 64'h0);
    chk($sformatf("rst%0d_last", g), dlast[g], 1'b0);
    chk($sformatf("rst%0d_err", g), derr[g], 1'b0);
    chk($sformatf("rst%0d_mem_req", g), mreq[g], 1'b0);
    chk($sformatf("rst%0d_mem_addr", g), maddr[g], 32'h0);
  endtask

  // Issue one fill request and follow it to completion, or stop after
  // stop_after beats when stop_after > 0. Call at a negedge. hold keeps the
  // request high until the last beat is seen.
  task automatic run_fill(input int g, input logic [28:0] addr, input bit hold,
                          input int stop_after);
    logic [31:0] eaddr [4];
    int          start;
    int          k;
    int          acks;
    int          target;
    start  = (g == 0) ? int'(addr[1:0]) : 0;
    target = (stop_after > 0) ? stop_after : 4;
    for (int i = 0; i < 4; i++) begin
      int b;
      b = (start + i) % 4;
      eaddr[i] = {addr[28:2], 5'b00000} + 32'(b * 8);
    end
    icu_req[g]  = 1'b1;
    icu_addr[g] = addr;
    @(negedge clk);
    chk($sformatf("ack%0d_latency", g), ack[g], 1'b1);
    acks = 1;
    k    = 0;
    if (!hold) icu_req[g] = 1'b0;
    for (int cyc = 0; cyc < 400 && k < target; cyc++) begin
      @(negedge clk);
      if (ack[g] === 1'b1) acks++;
      if (dv[g] === 1'b1) begin
        chk($sformatf("data%0d_b%0d", g, k), ddata[g], mem_word(eaddr[k], salt[g]));
        chk($sformatf("err%0d_b%0d", g, k), derr[g], errmask[g][eaddr[k][4:3]]);
        chk($sformatf("last%0d_b%0d", g, k), dlast[g], (k == 3));
        k++;
        if (k == 4 && hold) icu_req[g] = 1'b0;
      end
      if (mreq[g] === 1'b1 && k < target)
        chk($sformatf("mem_addr%0d_b%0d", g, k), maddr[g], eaddr[k]);
    end
    chk($sformatf("beats%0d", g), k, target);
    chk($sformatf("ack_count%0d", g), acks, 1);
  endtask

  initial begin : stimulus
    logic [28:0] raddr;
    int          rg;
    int          st;

    resetn = 1'b0;
    for (int g = 0; g < 2; g++) begin
      icu_req[g] = 1'b0; icu_addr[g] = '0;
      set_mem(g, 0, 0, 0, 0, 32'h0, 4'h0);
    end
    repeat (3) @(negedge clk);
    reset_outputs_check(0);
    reset_outputs_check(1);
    resetn = 1'b1;
    @(negedge clk);

    // 1: critical word first, grant same cycle, data one cycle after grant.
    set_mem(0, 0, 0, 0, 0, 32'h1111_0000, 4'h0);
    run_fill(0, 29'h2021, 1'b0, 0);
    idle_check(0, 2);

    // 2: linear order from beat 0 regardless of the critical beat.
    set_mem(1, 0, 0, 0, 0, 32'hbbbb_cccc, 4'h0);
    run_fill(1, 29'h2022, 1'b0, 0);
    idle_check(1, 2);

    // 3: slow grant and slow data; request and address must hold while waiting.
    set_mem(0, 3, 3, 5, 5, 32'h3333_5555, 4'h0);
    run_fill(0, 29'h1F_FFFF, 1'b0, 0);
    idle_check(0, 1);

    // 4: request held across a whole fill, then a second fill one cycle later.
    set_mem(0, 0, 1, 0, 2, 32'h4444_0001, 4'h0);
    run_fill(0, 29'h0ABC_DE3, 1'b1, 0);
    idle_check(0, 1);
    set_mem(0, 0, 1, 0, 2, 32'h4444_0002, 4'h0);
    run_fill(0, 29'h0123_450, 1'b0, 0);
    idle_check(0, 1);

    // 5: error on the second returned beat only (critical beat 2, so beat 3).
    set_mem(0, 0, 2, 0, 2, 32'h5555_aaaa, 4'b1000);
    run_fill(0, 29'h0777_772, 1'b0, 0);
    idle_check(0, 1);

    // 6: reset after two beats while a read is outstanding, then a late return.
    set_mem(0, 0, 0, 3, 3, 32'h6666_0000, 4'h0);
    run_fill(0, 29'h0246_8AD, 1'b0, 2);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    reset_outputs_check(0);
    @(negedge clk);
    resetn = 1'b1;
    idle_check(0, 8);
    set_mem(0, 0, 1, 0, 1, 32'h6666_0001, 4'h0);
    run_fill(0, 29'h0246_8AD, 1'b0, 0);
    idle_check(0, 1);

    // Randomised fills on either instance.
    for (int n = 0; n < 16; n++) begin
      rg    = int'($urandom_range(1, 0));
      raddr = 29'($urandom);
      set_mem(rg, 0, int'($urandom_range(3, 0)), 0, int'($urandom_range(4, 0)),
              $urandom, 4'($urandom));
      st = int'($urandom_range(1, 0));
      run_fill(rg, raddr, st[0], 0);
      idle_check(rg, int'($urandom_range(2, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
